ocp_arbiter: RTL and testbench

OCP_ARBITER -- requirements
Module: ocp_arbiter

---
 rtl/ocp_arbiter_if.sv | 40 ++++
 rtl/ocp_arbiter.sv | 131 +++++++++++++
 tb/tb_ocp_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocp_arbiter_if.sv
// Bundle of the N-requester OCP command bus and the shared slave-side command bus
// that the arbiter multiplexes onto.
interface ocp_arbiter_if #(
   parameter int N_REQ     = 4,
   parameter int ADDR_WDTH = 64,
   parameter int DATA_WDTH = 8
);
   // Handshake: a requester holds read/write plus its attributes stable until the
   // cycle in which it sees req_cmd_accept high; that cycle is the transfer. The
   // slave side is the same contract on read_request/write_request vs s_cmd_accept.
   logic [N_REQ-1:0]           req_read;
   logic [N_REQ-1:0]           req_write;
   logic [N_REQ*ADDR_WDTH-1:0] req_address;
   logic [N_REQ*10-1:0]        req_burst_length;
   logic [N_REQ*DATA_WDTH-1:0] req_write_data;
   logic [N_REQ-1:0]           req_cmd_accept;
   logic [N_REQ-1:0]           grant;
   logic [ADDR_WDTH-1:0]       address;
   logic                       read_request;
   logic                       write_request;
   logic [9:0]                 burst_length;
   logic [DATA_WDTH-1:0]       write_data;
   logic                       s_cmd_accept;
   logic                       busy;
   logic                       proto_err;

   modport slave (
      input  req_read, req_write, req_address, req_burst_length, req_write_data,
      input  s_cmd_accept,
      output req_cmd_accept, grant, address, read_request, write_request,
      output burst_length, write_data, busy, proto_err
   );

   modport master (
      output req_read, req_write, req_address, req_burst_length, req_write_data,
      output s_cmd_accept,
      input  req_cmd_accept, grant, address, read_request, write_request,
      input  burst_length, write_data, busy, proto_err
   );
endinterface

// File: rtl/ocp_arbiter.sv
// Round-robin burst arbiter: grants one OCP requester at a time and holds the
// grant for the whole burst, muxing the owner's command onto the slave bus.
module ocp_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_WDTH = 64,
   parameter int DATA_WDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   ocp_arbiter_if.slave  bus,
   output logic [1:0]    dbg_state
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BURST = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   active;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic [9:0]         beat_cnt_q, beat_cnt_d;
   logic [9:0]         total_q, total_d;
   logic [9:0]         owner_bl;
   logic               owned, own_rd, own_wr;
   logic               illegal, illegal_q;
   logic               beat;

   assign active = bus.req_read | bus.req_write;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      win_idx   = last_q;
      win_found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!win_found && active[(int'(last_q) + k) % N_REQ]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((int'(last_q) + k) % N_REQ);
         end
      end
   end

   assign owned    = |grant_q;
   assign own_rd   = owned & bus.req_read[owner_q];
   assign own_wr   = owned & bus.req_write[owner_q];
   assign owner_bl = bus.req_burst_length[int'(owner_q)*10 +: 10];
   assign illegal  = own_rd & own_wr;
   assign beat     = (state_q == BURST) & (own_rd ^ own_wr) & bus.s_cmd_accept;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      total_d    = total_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               owner_d = win_idx;
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            end
         end
         GRANT: begin
            total_d    = (owner_bl == 10'd0) ? 10'd1 : owner_bl;
            beat_cnt_d = 10'd0;
            state_d    = BURST;
         end
         BURST: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 10'd1;
               if (beat_cnt_q + 10'd1 == total_q) begin
                  grant_d = '0;
                  last_d  = owner_q;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         last_q     <= IDX_W'(N_REQ - 1);
         beat_cnt_q <= 10'd0;
         total_q    <= 10'd0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
         total_q    <= total_d;
         illegal_q  <= illegal;
      end
   end

   // Everything on the slave side derives from grant_q, so a cleared grant
   // (including asynchronous reset) forces the whole bus to zero.
   always_comb begin
      bus.address       = '0;
      bus.burst_length  = '0;
      bus.write_data    = '0;
      bus.read_request  = 1'b0;
      bus.write_request = 1'b0;
      if (owned) begin
         bus.address       = bus.req_address[int'(owner_q)*ADDR_WDTH +: ADDR_WDTH];
         bus.burst_length  = owner_bl;
         bus.write_data    = bus.req_write_data[int'(owner_q)*DATA_WDTH +: DATA_WDTH];
         bus.read_request  = own_rd & ~own_wr;
         bus.write_request = own_wr & ~own_rd;
      end
   end

   assign bus.grant          = grant_q;
   assign bus.req_cmd_accept = grant_q & {N_REQ{bus.s_cmd_accept && (state_q == BURST)}};
   assign bus.busy           = (state_q != IDLE);
   assign bus.proto_err      = illegal & ~illegal_q;
   assign dbg_state          = state_q;
endmodule

// File: tb/tb_ocp_arbiter.sv
// Bench for ocp_arbiter: directed scenarios with a beat scoreboard fed by the
// stimulus and drained by a negedge monitor.
module tb_ocp_arbiter;
   localparam int N  = 4;
   localparam int AW = 64;
   localparam int DW = 8;
   localparam int W  = N + 2 + DW;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   ocp_arbiter_if #(.N_REQ(N), .ADDR_WDTH(AW), .DATA_WDTH(DW)) bus ();

   ocp_arbiter #(.N_REQ(N), .ADDR_WDTH(AW), .DATA_WDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int             n_checks   = 0;
   int             n_errors   = 0;
   int             beat_seen  = 0;
   int             acc2       = 0;
   int             acc_base;
   logic [W-1:0]   exp_q[$];
   logic [DW-1:0]  wd [N];
   logic [AW-1:0]  ad [N];
   logic [N-1:0]   prev_g = '0;
   logic [W-1:0]   mon_obs, mon_exp;
   logic [5:0]     pat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int i, input logic rd, input logic wr, input logic [9:0] bl);
      wd[i] = 8'($urandom_range(0, 255));
      ad[i] = {$urandom, $urandom};
      bus.req_read[i]                   = rd;
      bus.req_write[i]                  = wr;
      bus.req_burst_length[i*10 +: 10]  = bl;
      bus.req_write_data[i*DW +: DW]    = wd[i];
      bus.req_address[i*AW +: AW]       = ad[i];
   endtask

   task automatic clear_reqs();
      bus.req_read  = '0;
      bus.req_write = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beats(input int i, input logic rd, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({N'(1 << i), rd, ~rd, wd[i]});
   endtask

   task automatic wait_beats(input int n);
      int target;
      int cyc;
      target = beat_seen + n;
      cyc    = 0;
      while (beat_seen < target && cyc < 300) begin
         @(posedge clk);
         cyc++;
      end
      if (beat_seen < target) check("beat_timeout", beat_seen, target);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] s);
      int cyc;
      cyc = 0;
      while (dbg_state !== s && cyc < 50) begin
         tick();
         cyc++;
      end
      if (dbg_state !== s) check("state_timeout", dbg_state, s);
   endtask

   // Monitor: a beat is an accepted cycle where the owner drives exactly one command.
   always @(negedge clk) begin
      if (!reset) begin
         prev_g = '0;
      end else begin
         acc2 += int'(bus.req_cmd_accept[2]);
         for (int i = 0; i < N; i++) begin
            if (bus.req_cmd_accept[i] && (bus.req_read[i] ^ bus.req_write[i])) begin
               beat_seen++;
               mon_obs = {bus.grant, bus.read_request, bus.write_request, bus.write_data};
               mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
               check("beat", mon_obs, mon_exp);
            end
         end
         if (prev_g != '0 && bus.grant != '0) check("grant_hold", bus.grant, prev_g);
         prev_g = bus.grant;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_read         = '0;
      bus.req_write        = '0;
      bus.req_address      = '0;
      bus.req_burst_length = '0;
      bus.req_write_data   = '0;
      bus.s_cmd_accept     = 1'b1;
      for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b0, 10'd2);
      repeat (2) @(posedge clk);
      #1;
      // Reset state while every requester is asking
      check("rst_grant", bus.grant, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_proto_err", bus.proto_err, 0);
      check("rst_read", bus.read_request, 0);
      check("rst_write", bus.write_request, 0);
      check("rst_address", bus.address, 0);
      check("rst_data", bus.write_data, 0);
      check("rst_blen", bus.burst_length, 0);
      check("rst_accept", bus.req_cmd_accept, 0);
      check("rst_state", dbg_state, 0);
      clear_reqs();

      // Two writers, burst 3 each: requester 0 then 2 with an idle gap
      drive_req(0, 1'b0, 1'b1, 10'd3);
      drive_req(2, 1'b0, 1'b1, 10'd3);
      push_beats(0, 1'b0, 3);
      push_beats(2, 1'b0, 3);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("arb_grant", bus.grant, 4'b0001);
      check("arb_state", dbg_state, 1);
      check("arb_busy", bus.busy, 1);
      check("mux_address", bus.address, ad[0]);
      check("mux_blen", bus.burst_length, 3);
      check("mux_write", bus.write_request, 1);
      wait_beats(3);
      check("gap_grant", bus.grant, 0);
      check("gap_busy", bus.busy, 0);
      bus.req_write[0] = 1'b0;
      wait_beats(3);
      check("end_grant", bus.grant, 0);
      clear_reqs();

      // All four reading with burst 1: 0,1,2,3,0
      reset = 1'b0;
      for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b0, 10'd1);
      push_beats(0, 1'b1, 1);
      push_beats(1, 1'b1, 1);
      push_beats(2, 1'b1, 1);
      push_beats(3, 1'b1, 1);
      push_beats(0, 1'b1, 1);
      @(negedge clk);
      reset = 1'b1;
      wait_beats(5);
      clear_reqs();
      check("rr_idle", bus.grant, 0);

      // Requester 2 reads 4 beats against a stalling slave
      bus.s_cmd_accept = 1'b0;
      drive_req(2, 1'b1, 1'b0, 10'd4);
      push_beats(2, 1'b1, 4);
      tick();
      wait_state(2'd2);
      acc_base = acc2;
      pat = 6'b110101;
      for (int k = 0; k < 6; k++) begin
         bus.s_cmd_accept = pat[k];
         tick();
      end
      check("accept_pulses", acc2 - acc_base, 4);
      check("stall_grant", bus.grant, 0);
      check("stall_busy", bus.busy, 0);
      check("stall_state", dbg_state, 0);
      clear_reqs();
      bus.s_cmd_accept = 1'b1;

      // Lone requester 1 wins after owner 2; illegal cmd, idle owner, ignored rival
      drive_req(1, 1'b0, 1'b1, 10'd3);
      push_beats(1, 1'b0, 3);
      tick();
      wait_state(2'd2);
      check("single_win", bus.grant, 4'b0010);
      bus.req_read[1] = 1'b1;
      drive_req(0, 1'b0, 1'b1, 10'd2);
      bus.req_burst_length[10 +: 10] = 10'd1;
      #1;
      check("proto_err_set", bus.proto_err, 1);
      check("proto_read", bus.read_request, 0);
      check("proto_write", bus.write_request, 0);
      check("proto_grant", bus.grant, 4'b0010);
      tick();
      check("proto_pulse", bus.proto_err, 0);
      check("proto_hold", bus.grant, 4'b0010);
      bus.req_read[1]  = 1'b0;
      bus.req_write[1] = 1'b0;
      tick();
      check("idle_owner_grant", bus.grant, 4'b0010);
      check("idle_owner_busy", bus.busy, 1);
      tick();
      bus.req_write[0] = 1'b0;
      bus.req_write[1] = 1'b1;
      wait_beats(3);
      check("latched_len_end", bus.grant, 0);
      check("latched_len_state", dbg_state, 0);
      clear_reqs();

      // Reset in the middle of a 5-beat burst
      drive_req(0, 1'b0, 1'b1, 10'd5);
      push_beats(0, 1'b0, 2);
      wait_beats(2);
      #2;
      reset = 1'b0;
      #1;
      check("abort_grant", bus.grant, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_write", bus.write_request, 0);
      check("abort_address", bus.address, 0);
      check("abort_accept", bus.req_cmd_accept, 0);
      check("abort_state", dbg_state, 0);
      for (int i = 1; i < N; i++) drive_req(i, 1'b1, 1'b0, 10'd1);
      bus.req_burst_length[0 +: 10] = 10'd1;
      push_beats(0, 1'b0, 1);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("post_rst_priority", bus.grant, 4'b0001);
      bus.req_read = '0;
      wait_beats(1);
      clear_reqs();

      // Burst length 0 behaves as one beat
      drive_req(3, 1'b0, 1'b1, 10'd0);
      push_beats(3, 1'b0, 1);
      wait_beats(1);
      clear_reqs();
      check("bl0_grant", bus.grant, 0);
      check("bl0_busy", bus.busy, 0);

      tick();
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
